// File: rtl/if_fetch_stage.sv
//------------------------------------------------------------------------------
// if_fetch_stage: PC register, next-PC select and IF/ID pipeline register
// with stall, redirect-squash and memory-wait bubble handling.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        id_stall,
  input  logic        id_jump,
  input  logic        id_jr,
  input  logic        id_br_taken,
  input  logic [31:0] id_rs_data,
  output logic [31:0] pc,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PC4,
  output logic        IF_ID_Valid,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] fcnt_q, fcnt_d;
  logic [31:0] bcnt_q, bcnt_d;

  logic [31:0] pc_plus4;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] redir_tgt;
  logic        redir;

  assign pc_plus4 = pc_q + 32'd4;
  assign br_tgt   = pc4_q + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign j_tgt    = {pc4_q[31:28], instr_q[25:0], 2'b00};
  assign redir    = valid_q & ~id_stall & (id_jump | id_jr | id_br_taken);

  // Register-indirect jumps outrank direct jumps, which outrank branches.
  assign redir_tgt = id_jr   ? id_rs_data :
                     id_jump ? j_tgt      :
                               br_tgt;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    fcnt_d  = fcnt_q;
    bcnt_d  = bcnt_q;
    if (id_stall) begin
      // Freeze everything; any returned word is dropped and refetched later.
    end else if (redir) begin
      pc_d    = redir_tgt;
      instr_d = NOP_INSTR;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
      bcnt_d  = bcnt_q + 32'd1;
    end else if (imem_ready) begin
      pc_d    = pc_plus4;
      instr_d = imem_rdata;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
      fcnt_d  = fcnt_q + 32'd1;
    end else begin
      instr_d = NOP_INSTR;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
      bcnt_d  = bcnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      fcnt_q  <= 32'd0;
      bcnt_q  <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      fcnt_q  <= fcnt_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign imem_req        = ~rst;
  assign imem_addr       = pc_q;
  assign pc              = pc_q;
  assign IF_ID_Instr     = instr_q;
  assign IF_ID_PC4       = pc4_q;
  assign IF_ID_Valid     = valid_q;
  assign perf_fetch_cnt  = fcnt_q;
  assign perf_bubble_cnt = bcnt_q;

endmodule

`default_nettype wire

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS core; directly upstream of the ID control decoder.
- Holds the PC and issues fetch requests to instruction memory.
- Selects the next PC from sequential, branch, J/JAL and JR/JALR targets resolved in ID.
- Drives IF_ID_Instr / IF_ID_PC4 into ID, with stall, flush and memory-wait bubble handling.
- No branch delay slot: a redirect squashes the wrong-path fetch.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, bubble encoding written into IF_ID_Instr (sll $0,$0,0)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
imem_req  output  1  fetch request, high whenever not in reset
imem_addr  output  32  equals pc
imem_rdata  input  32  instruction word, valid when imem_ready=1
imem_ready  input  1  memory has returned data for imem_addr this cycle
id_stall  input  1  hazard unit: freeze PC and IF/ID
id_jump  input  1  ID holds J/JAL (isJOrJal)
id_jr  input  1  ID holds JR/JALR (isJrOrJalr)
id_br_taken  input  1  ID branch resolved taken
id_rs_data  input  32  forwarded rs value, the JR target
pc  output  32  current fetch PC
IF_ID_Instr  output  32  instruction presented to ID
IF_ID_PC4  output  32  PC+4 of that instruction
IF_ID_Valid  output  1  1 = real instruction, 0 = bubble
perf_fetch_cnt  output  32  count of instructions accepted into IF/ID
perf_bubble_cnt  output  32  count of bubbles inserted into IF/ID

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - pc=RESET_PC
  - IF_ID_Instr=NOP_INSTR, IF_ID_PC4=0, IF_ID_Valid=0
  - both perf counters=0
  - rst dominates everything, including mid-wait and mid-redirect.
- Targets: computed combinationally from the current IF/ID contents, 32-bit, wrap mod 2^32.
  - br_tgt = IF_ID_PC4 + (sext(IF_ID_Instr[15:0])<<2)
  - j_tgt = {IF_ID_PC4[31:28], IF_ID_Instr[25:0], 2'b00}
  - jr_tgt = id_rs_data; low 2 bits are passed through unchecked.
- Redirect:
  - redir = IF_ID_Valid & !id_stall & (id_jump|id_jr|id_br_taken).
  - Target priority if more than one is asserted: jr > jump > branch.
  - Redirect requests with IF_ID_Valid=0 are ignored.
- Per-cycle priority, highest first:
  1. rst.
  2. id_stall=1: pc and all IF/ID registers hold. Redirect inputs are ignored. Memory response is discarded and refetched later. Counters hold.
  3. redir=1: pc<=target. IF/ID<=bubble (Instr=NOP_INSTR, PC4=0, Valid=0), whatever imem_ready is. perf_bubble_cnt+1.
  4. imem_ready=1: IF_ID_Instr<=imem_rdata, IF_ID_PC4<=pc+4, IF_ID_Valid<=1. pc<=pc+4. perf_fetch_cnt+1.
  5. imem_ready=0: pc holds. IF/ID<=bubble. perf_bubble_cnt+1.
- Latency and throughput:
  - Instruction fetched at pc in cycle N (ready=1, no stall, no redirect) appears on IF_ID_* in cycle N+1.
  - Peak throughput is one instruction per cycle.
  - Redirect penalty is exactly one bubble.
- pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 silently.
- Perf counters wrap at 2^32 silently.
- Per non-reset cycle, exactly one counter increments unless stalled. Invariant: fetch + bubble = non-stall, non-reset cycles (mod 2^32).
- imem_addr is a direct copy of pc, so the memory sees a redirected address in the cycle after the redirect.

Test Plan:
1. Reset then sequential fetch: rst=1 one cycle; imem_ready=1; memory returns 32'h2008_0005 at 0x3000 and 32'h2009_0003 at 0x3004.
   -> pc 0x3000, 0x3004, 0x3008 on successive cycles; IF_ID_Instr=0x20080005 with IF_ID_PC4=0x3004, IF_ID_Valid=1; perf_fetch_cnt=2 after two fetches.
2. Stall hold: assert id_stall for 3 cycles while IF_ID holds 0x20090003.
   -> pc, IF_ID_Instr and IF_ID_PC4 are unchanged for all 3 cycles; counters unchanged; fetch resumes at the same pc on the cycle after release.
3. Taken branch: IF_ID_Instr=0x1000_FFFE (beq, offset -2), IF_ID_PC4=0x3010, id_br_taken=1.
   -> next pc=0x3008; IF_ID_Valid=0 and IF_ID_Instr=0 for one cycle; perf_bubble_cnt+1.
4. J and JR, including simultaneous assertion:
   - IF_ID_Instr=0x0800_0C10, IF_ID_PC4=0x3020, id_jump=1 -> pc=0x0000_3040.
   - id_jr=1, id_jump=1, id_rs_data=0x0000_3100 -> pc=0x3100 (jr wins).
5. Memory wait: imem_ready=0 for 2 cycles at pc 0x300C.
   -> pc holds 0x300C; two bubbles; perf_bubble_cnt+2.
   - Also apply a redirect during the wait -> pc takes the target and the stale rdata is never loaded.
6. Stall masks redirect, then reset mid-operation:
   - id_stall=1 with id_br_taken=1 -> no pc change.
   - rst=1 while IF_ID_Valid=1 and pc=0x3050 -> next cycle pc=0x3000, IF_ID_Valid=0, counters=0.
